// File: rtl/vslc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// vslc_scan_sequencer
//
// Scan-cycle scheduler for the vslc logic-controller core. Each scan is
//   LATCH  (one cycle, core samples its inputs)
//   EXEC   (one instruction per accepted exec_valid/exec_ready handshake)
//   COMMIT (one cycle, core drives its outputs)
//   WAIT   (at least one cycle, until the scan period has elapsed)
// and scans repeat while run & ena stay high. A scan that is still busy when
// its period runs out raises the sticky overrun flag and the next LATCH
// follows after a single WAIT cycle.
//
// Handshake: exec_valid is high for the whole EXEC state and pc is held while
// exec_ready is low; an instruction is consumed on every rising clk edge where
// exec_valid and exec_ready are both 1.
//
// Optional build macro: VSLC_SCAN_WDOG_EN
//   Adds an 8-bit per-instruction stall watchdog. When an instruction has been
//   stalled for WDOG_LIM cycles the scan is abandoned (no COMMIT), the sticky
//   fault flag is raised and no new scan starts until clr_flags.
//   Without the macro there is no watchdog and fault is constant 0.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   ena, run     scans start / continue only while both are 1
//   prog_end     address of the last instruction (sampled in LATCH)
//   period       LATCH-to-LATCH period in cycles, 0 = free-run (sampled in LATCH)
//   exec_ready   core accepted the instruction at pc
//   clr_flags    synchronous clear of overrun/fault (a same-cycle set wins)
//   in_latch     1-cycle pulse in LATCH
//   exec_valid   instruction at pc pending
//   pc           instruction address
//   out_commit   1-cycle pulse in COMMIT
//   busy         sequencer is not idle
//   overrun      sticky: a scan did not fit in its period
//   fault        sticky: instruction watchdog tripped
//   scan_cnt     completed scans, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vslc_scan_sequencer #(
  parameter int PC_W     = 4,
  parameter int PERIOD_W = 16,
  parameter int WDOG_LIM = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                run,
  input  logic [PC_W-1:0]     prog_end,
  input  logic [PERIOD_W-1:0] period,
  input  logic                exec_ready,
  input  logic                clr_flags,
  output logic                in_latch,
  output logic                exec_valid,
  output logic [PC_W-1:0]     pc,
  output logic                out_commit,
  output logic                busy,
  output logic                overrun,
  output logic                fault,
  output logic [7:0]          scan_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_COMMIT = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PC_W-1:0]       r_pc;
  logic [PC_W-1:0]       r_prog_end;
  logic [PERIOD_W-1:0]   r_timer;
  logic                  r_timed;
  logic [7:0]            r_scan_cnt;
  logic                  r_overrun;
  logic                  w_start;
  logic                  w_last_instr;
  logic                  w_ovr_set;
  logic                  w_wdog_trip;

  assign w_start      = run & ena & ~fault;
  assign w_last_instr = (r_pc == r_prog_end);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_wdog_trip)                      w_state_nxt = S_IDLE;
        else if (exec_ready && w_last_instr)  w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_timer <= PERIOD_W'(1)) w_state_nxt = w_start ? S_LATCH : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pure Moore decode)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_latch   = 1'b0;
    exec_valid = 1'b0;
    out_commit = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_LATCH:  in_latch   = 1'b1;
      S_EXEC:   exec_valid = 1'b1;
      S_COMMIT: out_commit = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program counter and latched scan configuration
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_prog_end <= '0;
      r_timed    <= 1'b0;
    end else if (r_state == S_LATCH) begin
      r_pc       <= '0;
      r_prog_end <= prog_end;
      r_timed    <= (period != '0);
    end else if (r_state == S_EXEC && exec_ready && !w_last_instr) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Period timer: holds the number of cycles left before the next LATCH,
  // counted from the cycle after LATCH. Loading period-1 makes WAIT exit on
  // the cycle where one cycle remains, so LATCH pulses land exactly period
  // cycles apart. Saturates at 0, which also gives free-run and overrun
  // scans their single WAIT cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == S_LATCH) begin
      r_timer <= (period == '0) ? '0 : period - PERIOD_W'(1);
    end else if (r_timer != '0) begin
      r_timer <= r_timer - PERIOD_W'(1);
    end
  end

  // Fewer than two cycles left at COMMIT means COMMIT + one WAIT cycle no
  // longer fits in the period.
  assign w_ovr_set = (r_state == S_COMMIT) && r_timed && (r_timer < PERIOD_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (clr_flags) begin
      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
    end else if (r_state == S_COMMIT) begin
      r_scan_cnt <= r_scan_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction watchdog
  // ---------------------------------------------------------------------------
`ifdef VSLC_SCAN_WDOG_EN
  localparam logic [7:0] LP_TRIP_AT = 8'(WDOG_LIM - 1);

  logic [7:0] r_stall;
  logic       r_fault;

  // Trips on the stall cycle that brings the count to WDOG_LIM.
  assign w_wdog_trip = (r_state == S_EXEC) && !exec_ready && (r_stall == LP_TRIP_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_state == S_LATCH || exec_ready) begin
      r_stall <= '0;
    end else if (r_state == S_EXEC) begin
      r_stall <= r_stall + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_wdog_trip) begin
      r_fault <= 1'b1;
    end else if (clr_flags) begin
      r_fault <= 1'b0;
    end
  end

  assign fault = r_fault;
`else
  // No watchdog: always 0 (the limit is a positive count). Referencing
  // WDOG_LIM keeps the parameter live in this build as well.
  assign w_wdog_trip = (WDOG_LIM < 0);
  assign fault       = 1'b0;
`endif

  assign pc       = r_pc;
  assign overrun  = r_overrun;
  assign scan_cnt = r_scan_cnt;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vslc_scan_sequencer
//
// Scoreboard bench. Each scan segment is generated up front; a scan-level
// model (absolute cycle arithmetic per scan) pushes the expected LATCH,
// instruction-accept and COMMIT events into exp_q, and an independent
// monitor pops and compares whenever the DUT shows one of those events.
// Directed checks cover reset values, reset mid-scan and stopping.
// -----------------------------------------------------------------------------
module tb_vslc_scan_sequencer;

  localparam int PC_W     = 4;
  localparam int PERIOD_W = 16;
  localparam int WDOG_LIM = 8;
  localparam int W        = 35;   // kind[2] cyc[20] pc[4] cnt[8] ovr[1]

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                ena = 1'b0;
  logic                run = 1'b0;
  logic [PC_W-1:0]     prog_end = '0;
  logic [PERIOD_W-1:0] period = '0;
  logic                exec_ready = 1'b0;
  logic                clr_flags = 1'b0;
  logic                in_latch;
  logic                exec_valid;
  logic [PC_W-1:0]     pc;
  logic                out_commit;
  logic                busy;
  logic                overrun;
  logic                fault;
  logic [7:0]          scan_cnt;

  vslc_scan_sequencer #(
    .PC_W     (PC_W),
    .PERIOD_W (PERIOD_W),
    .WDOG_LIM (WDOG_LIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .run        (run),
    .prog_end   (prog_end),
    .period     (period),
    .exec_ready (exec_ready),
    .clr_flags  (clr_flags),
    .in_latch   (in_latch),
    .exec_valid (exec_valid),
    .pc         (pc),
    .out_commit (out_commit),
    .busy       (busy),
    .overrun    (overrun),
    .fault      (fault),
    .scan_cnt   (scan_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state and model state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           stall_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  bit           hold_low = 1'b0;
  int           m_cnt = 0;
  int           m_pc = 0;
  bit           m_ovr = 1'b0;

  function automatic logic [W-1:0] pack_ev(input int kind, input int t, input int pcv,
                                           input int cnt, input bit ovr);
    return {2'(kind), 20'(t), 4'(pcv), 8'(cnt), ovr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance (in posedge+1 steps) to the given cycle index.
  task automatic wait_until(input int target);
    if (cyc > target) begin
      checks++;
      errors++;
      $display("FAIL schedule got_cycle=%0d want_cycle=%0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: exec_ready. Consumes one stall count per instruction: holds ready
  // low for that many cycles of exec_valid, then accepts.
  // ---------------------------------------------------------------------------
  initial begin : ready_drv
    int cur;
    bit have;
    cur  = 0;
    have = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) begin
        exec_ready = 1'b0;
      end else if (exec_valid) begin
        if (!have) begin
          cur  = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
          have = 1'b1;
        end
        if (cur > 0) begin
          exec_ready = 1'b0;
          cur--;
        end else begin
          exec_ready = 1'b1;
          have       = 1'b0;
        end
      end else begin
        exec_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops one expected event per observed LATCH / accept / COMMIT.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [W-1:0] act;
    logic [W-1:0] exp;
    int kind;
    forever begin
      @(negedge clk);
      if (mon_en && (in_latch || out_commit || (exec_valid && exec_ready))) begin
        kind = in_latch ? 0 : (out_commit ? 2 : 1);
        act  = pack_ev(kind, cyc, int'(pc), int'(scan_cnt), overrun);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d cyc=%0d pc=%0d cnt=%0d ovr=%0b",
                   act[34:33], act[32:13], act[12:9], act[8:1], act[0]);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL scan_event got kind=%0d cyc=%0d pc=%0d cnt=%0d ovr=%0b want kind=%0d cyc=%0d pc=%0d cnt=%0d ovr=%0b",
                     act[34:33], act[32:13], act[12:9], act[8:1], act[0],
                     exp[34:33], exp[32:13], exp[12:9], exp[8:1], exp[0]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One segment of back-to-back scans, then stop via run or ena.
  // Scan model: LATCH at l; instruction k accepted after its stalls; COMMIT
  // the cycle after the last accept. A scan of d = commit-l cycles overruns
  // when period != 0 and period < d + 2; the next LATCH is at l + period,
  // or commit + 2 when free-running or overrun.
  // ---------------------------------------------------------------------------
  task automatic run_segment(input int n, input bit rnd, input int fp, input int ft,
                             input bit drop_ena);
    int pa[$];
    int ta[$];
    int la[$];
    bit ca[$];
    int st, v, a, c, l, d, l_end;
    bit prev, mid, ov;
    for (int i = 0; i < n; i++) begin
      pa.push_back(rnd ? int'($urandom_range(0, 15)) : fp);
      if (rnd) ta.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30)));
      else     ta.push_back(ft);
      ca.push_back($urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    #1;
    prog_end = PC_W'(pa[0]);
    period   = PERIOD_W'(ta[0]);
    run      = 1'b1;
    ena      = 1'b1;
    l = cyc + 1;
    for (int i = 0; i < n; i++) begin
      la.push_back(l);
      prev = m_ovr;
      mid  = ca[i] ? 1'b0 : prev;
      exp_q.push_back(pack_ev(0, l, m_pc, m_cnt, prev));
      v = l + 1;
      for (int k = 0; k <= pa[i]; k++) begin
        st = (rnd && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 3)) : 0;
        stall_q.push_back(st);
        a = v + st;
        exp_q.push_back(pack_ev(1, a, k, m_cnt, (a == l + 1) ? prev : mid));
        v = a + 1;
      end
      c = v;
      exp_q.push_back(pack_ev(2, c, pa[i], m_cnt, mid));
      d     = c - l;
      ov    = (ta[i] != 0) && (ta[i] < d + 2);
      m_ovr = mid | ov;
      m_cnt = (m_cnt + 1) % 256;
      m_pc  = pa[i];
      l     = (ta[i] == 0 || ov) ? c + 2 : l + ta[i];
    end
    l_end = l;
    // Next scan's configuration is applied mid-scan; the last scan sees
    // scrambled inputs plus the stop request.
    for (int i = 0; i < n; i++) begin
      wait_until(la[i] + 1);
      if (i + 1 < n) begin
        prog_end = PC_W'(pa[i+1]);
        period   = PERIOD_W'(ta[i+1]);
      end else begin
        prog_end = PC_W'($urandom_range(0, 15));
        period   = PERIOD_W'($urandom_range(0, 40));
        if (drop_ena) ena = 1'b0;
        else          run = 1'b0;
      end
      clr_flags = ca[i];
      wait_until(la[i] + 2);
      clr_flags = 1'b0;
    end
    wait_until(l_end - 1);
    chk("busy_in_last_wait", 32'(busy), 32'd1);
    wait_until(l_end);
    chk("idle_after_stop", 32'(busy), 32'd0);
    wait_until(l_end + 3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int s;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_latch",   32'(in_latch),   32'd0);
    chk("rst_exec_valid", 32'(exec_valid), 32'd0);
    chk("rst_pc",         32'(pc),         32'd0);
    chk("rst_out_commit", 32'(out_commit), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_overrun",    32'(overrun),    32'd0);
    chk("rst_fault",      32'(fault),      32'd0);
    chk("rst_scan_cnt",   32'(scan_cnt),   32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_segment(3,   1'b0, 3, 20, 1'b0);   // timed, fits in period
    run_segment(4,   1'b0, 3, 6,  1'b1);   // every scan overruns
    run_segment(258, 1'b0, 1, 0,  1'b0);   // free-run, scan_cnt wraps
    run_segment(60,  1'b1, 0, 0,  1'b1);   // random config and stalls

    // Reset in the middle of EXEC: everything drops in the same cycle.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    prog_end = PC_W'(3);
    period   = PERIOD_W'(20);
    run      = 1'b1;
    ena      = 1'b1;
    s = cyc;
    wait_until(s + 3);
    chk("exec_before_reset", 32'({busy, exec_valid}), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_exec", 32'({in_latch, exec_valid, pc, out_commit, busy, overrun, fault, scan_cnt}), 32'd0);
    run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 0;
    m_pc  = 0;
    m_ovr = 1'b0;

`ifdef VSLC_SCAN_WDOG_EN
    // Stuck core: watchdog trips on the 8th stall cycle, no restart until clear.
    hold_low = 1'b1;
    @(posedge clk);
    #1;
    prog_end = PC_W'(2);
    period   = PERIOD_W'(0);
    run      = 1'b1;
    s = cyc + 1;
    wait_until(s + 8);
    chk("wdog_before_trip", 32'({fault, exec_valid}), 32'd1);
    wait_until(s + 9);
    chk("wdog_tripped", 32'({fault, busy, exec_valid}), 32'd4);
    wait_until(s + 16);
    chk("wdog_no_restart", 32'({fault, busy}), 32'd2);
    clr_flags = 1'b1;
    s = cyc;
    wait_until(s + 1);
    clr_flags = 1'b0;
    chk("wdog_cleared", 32'(fault), 32'd0);
    wait_until(s + 2);
    chk("wdog_restart", 32'(in_latch), 32'd1);
    hold_low = 1'b0;
    run = 1'b0;
    wait_until(s + 14);
    chk("wdog_final_idle", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
